// File: rtl/mc_mem_stage_pkg.sv
// Shared types and constants for the multi-cycle memory-access stage.
// The FSM state encoding is exported so the debug state port can be decoded.
package mc_mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mc_mem_stage_if.sv
// Bus between the memory stage (master) and the unified instruction/data memory (slave).
interface mc_mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: the master raises req with addr/we/wdata stable and holds them until the
  // edge after the slave's one-cycle ack (or until it aborts on timeout). rdata is valid
  // only in the ack cycle; an ack seen while req is low is ignored.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ack);
  modport slave  (input  req, input we, input addr, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/mc_bus_timeout.sv
// Saturating wait counter for an outstanding bus request; expire fires in the
// TIMEOUT_CYC-th enabled cycle after clear.
module mc_bus_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] SAT  = {CW{1'b1}};

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != SAT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mc_mem_stage.sv
// Memory-access stage for the multi-cycle CPU: address mux, req/ack bus cycle,
// IR/MDR load, and a stall that holds the control FSM until the access completes.
module mc_mem_stage
  import mc_mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mem_data,
  output logic              misalign_err,
  output logic              bus_err,
  output state_t            dbg_state,
  mc_mem_stage_if.master    bus
);

  state_t            state, state_next;
  logic              access;
  logic [ADDR_W-1:0] addr;
  logic              issue, flag_misalign, complete, abort;
  logic              dest_ir;
  logic              expire;

  assign access    = MemRead | MemWrite;
  assign addr      = (IorD == IORD_ALU) ? alu_out : pc;
  assign dbg_state = state;

  mc_bus_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (issue),
    .enable (state == ST_BUSY),
    .expire (expire)
  );

  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    flag_misalign = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    stall         = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = access;
        if (access) begin
          if (is_aligned(addr[1:0])) begin
            issue      = 1'b1;
            state_next = ST_BUSY;
          end else begin
            flag_misalign = 1'b1;
            state_next    = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        // An ack arriving in the expiry cycle still completes the access.
        if (bus.ack) begin
          complete   = 1'b1;
          state_next = ST_DONE;
        end else if (expire) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bus.req      <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr     <= '0;
      bus.wdata    <= '0;
      dest_ir      <= 1'b0;
      instr        <= '0;
      mem_data     <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) begin
        bus.req   <= 1'b1;
        bus.we    <= MemWrite;
        bus.addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus.wdata <= wr_data;
        dest_ir   <= IRWrite;
      end
      if (complete || abort) bus.req <= 1'b0;
      if (complete && !bus.we) begin
        if (dest_ir) instr    <= bus.rdata;
        else         mem_data <= bus.rdata;
      end
      if (flag_misalign) misalign_err <= 1'b1;
      if (abort)         bus_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_mem_stage.sv
// Directed and randomized accesses checked against a per-transaction reference model.
module tb_mc_mem_stage;
  import mc_mem_stage_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] wr_data;
  logic          IorD, MemRead, MemWrite, IRWrite;
  logic          stall, misalign_err, bus_err;
  logic [DW-1:0] instr, mem_data;
  state_t        dbg_state;

  mc_mem_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mc_mem_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .alu_out     (alu_out),
    .wr_data     (wr_data),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .stall       (stall),
    .instr       (instr),
    .mem_data    (mem_data),
    .misalign_err(misalign_err),
    .bus_err     (bus_err),
    .dbg_state   (dbg_state),
    .bus         (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state and scoreboard
  logic [DW-1:0] m_instr, m_mdr;
  logic          m_mis, m_berr;
  logic [31:0]   exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one access either misaligns, completes after d wait
  // cycles, or times out after TO cycles. Pushes the expected observations.
  task automatic model_access(input logic iord, input logic rd, input logic wr,
                              input logic irw, input logic [31:0] pcv,
                              input logic [31:0] aluv, input logic [31:0] wdv,
                              input int d, input logic [31:0] rdv);
    logic [31:0] a;
    int          n_stall, n_req;
    a = iord ? aluv : pcv;
    if (a % 4 != 0) begin
      n_stall = 1; n_req = 0; m_mis = 1'b1;
    end else if (d >= 1 && d <= TO) begin
      n_stall = 1 + d; n_req = d;
      if (rd && !wr) begin
        if (irw) m_instr = rdv;
        else     m_mdr   = rdv;
      end
    end else begin
      n_stall = 1 + TO; n_req = TO; m_berr = 1'b1;
    end
    exp_q.push_back(32'(n_stall));
    exp_q.push_back(32'(n_req));
    exp_q.push_back(n_req > 0 ? a : 32'h0);
    exp_q.push_back(n_req > 0 ? 32'(wr) : 32'h0);
    exp_q.push_back(n_req > 0 ? wdv : 32'h0);
    exp_q.push_back(m_instr);
    exp_q.push_back(m_mdr);
    exp_q.push_back(32'(m_mis));
    exp_q.push_back(32'(m_berr));
    exp_q.push_back(32'(ST_IDLE));
  endtask

  // Driver: presents one access, plays the memory (ack in the d-th request cycle,
  // d=0 never), scrambles inputs while busy, then scores the outcome.
  task automatic do_access(input logic iord, input logic rd, input logic wr,
                           input logic irw, input logic [31:0] pcv,
                           input logic [31:0] aluv, input logic [31:0] wdv,
                           input int d, input logic [31:0] rdv);
    int          n_stall, n_req;
    logic [31:0] c_addr, c_we, c_wd;
    logic        done;
    model_access(iord, rd, wr, irw, pcv, aluv, wdv, d, rdv);
    pc = pcv; alu_out = aluv; wr_data = wdv; IorD = iord;
    MemRead = rd; MemWrite = wr; IRWrite = irw; bus.rdata = rdv;
    n_stall = 0; n_req = 0; c_addr = 0; c_we = 0; c_wd = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (bus.req) begin
        n_req++;
        c_addr = bus.addr; c_we = 32'(bus.we); c_wd = bus.wdata;
        if (n_req == d) bus.ack = 1'b1;
      end
      if (stall) n_stall++;
      else       done = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0;
      if (!done && n_req > 0) begin
        pc = $urandom; alu_out = $urandom; wr_data = $urandom;
        IorD = 1'($urandom); IRWrite = 1'($urandom);
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    chk("bound", 32'(done), 32'h1);
    #1;
    chk("stall_cycles", 32'(n_stall),        exp_q.pop_front());
    chk("req_cycles",   32'(n_req),          exp_q.pop_front());
    chk("bus_addr",     c_addr,              exp_q.pop_front());
    chk("bus_we",       c_we,                exp_q.pop_front());
    chk("bus_wdata",    c_wd,                exp_q.pop_front());
    chk("instr",        instr,               exp_q.pop_front());
    chk("mem_data",     mem_data,            exp_q.pop_front());
    chk("misalign_err", 32'(misalign_err),   exp_q.pop_front());
    chk("bus_err",      32'(bus_err),        exp_q.pop_front());
    chk("state",        32'(dbg_state),      exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] a, rdv;
    int          kind;
    reset_n = 1'b0; pc = '0; alu_out = '0; wr_data = '0;
    IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
    m_instr = '0; m_mdr = '0; m_mis = 1'b0; m_berr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",    32'(stall),        32'h0);
    chk("rst_req",      32'(bus.req),      32'h0);
    chk("rst_we",       32'(bus.we),       32'h0);
    chk("rst_addr",     bus.addr,          32'h0);
    chk("rst_instr",    instr,             32'h0);
    chk("rst_mem_data", mem_data,          32'h0);
    chk("rst_errs",     {30'h0, misalign_err, bus_err}, 32'h0);
    chk("rst_state",    32'(dbg_state),    32'(ST_IDLE));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // fetch, ack in third request cycle
    do_access(IORD_PC, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 3, 32'h8C220004);
    chk("t1_instr", instr, 32'h8C220004);
    // store, ack in first request cycle
    do_access(IORD_ALU, 1'b0, 1'b1, 1'b0, 32'h44, 32'h100, 32'hDEADBEEF, 1, 32'h11111111);
    // load to MDR
    do_access(IORD_ALU, 1'b1, 1'b0, 1'b0, 32'h48, 32'h104, 32'h0, 2, 32'hCAFEF00D);
    // misaligned load
    do_access(IORD_ALU, 1'b1, 1'b0, 1'b0, 32'h4C, 32'h102, 32'h0, 1, 32'h22222222);
    chk("t3_misalign", 32'(misalign_err), 32'h1);
    // read and write together: write wins, IR untouched
    do_access(IORD_ALU, 1'b1, 1'b1, 1'b1, 32'h50, 32'h200, 32'h0BADF00D, 2, 32'h33333333);
    // ack exactly in the expiry cycle still completes
    do_access(IORD_ALU, 1'b1, 1'b0, 1'b0, 32'h54, 32'h208, 32'h0, TO, 32'h5A5A5A5A);
    // timeout with no ack
    do_access(IORD_PC, 1'b1, 1'b0, 1'b1, 32'h58, 32'h0, 32'h0, 0, 32'h44444444);
    chk("t4_bus_err", 32'(bus_err), 32'h1);

    // late ack while idle must not load anything
    bus.ack = 1'b1; bus.rdata = 32'h12345678;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    #1;
    chk("late_ack_instr", instr,           m_instr);
    chk("late_ack_mdr",   mem_data,        m_mdr);
    chk("late_ack_state", 32'(dbg_state),  32'(ST_IDLE));

    // reset in the middle of a fetch, ack arrives after reset
    pc = 32'h80; IorD = IORD_PC; MemRead = 1'b1; IRWrite = 1'b1;
    @(posedge clk); #1;
    chk("rb_req_up", 32'(bus.req), 32'h1);
    reset_n = 1'b0; MemRead = 1'b0; IRWrite = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; bus.ack = 1'b1; bus.rdata = 32'hFFFF0000;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    #1;
    m_instr = '0; m_mdr = '0; m_mis = 1'b0; m_berr = 1'b0;
    chk("rb_req",      32'(bus.req),   32'h0);
    chk("rb_instr",    instr,          32'h0);
    chk("rb_mem_data", mem_data,       32'h0);
    chk("rb_state",    32'(dbg_state), 32'(ST_IDLE));
    chk("rb_stall",    32'(stall),     32'h0);
    chk("rb_errs",     {30'h0, misalign_err, bus_err}, 32'h0);

    // randomized accesses
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a    = {20'($urandom), 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      rdv  = $urandom;
      case (kind)
        0: do_access(IORD_PC,  1'b1, 1'b0, 1'b1, a, $urandom, $urandom, $urandom_range(0, 6), rdv);
        1: do_access(IORD_ALU, 1'b1, 1'b0, 1'b0, $urandom, a, $urandom, $urandom_range(0, 6), rdv);
        2: do_access(IORD_ALU, 1'b0, 1'b1, 1'($urandom), $urandom, a, $urandom, $urandom_range(0, 6), rdv);
        default: do_access(IORD_ALU, 1'b1, 1'b1, 1'b1, $urandom, a, $urandom, $urandom_range(0, 6), rdv);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
